// File: rtl/uart_tx_pkg.sv
// Shared types and default sizing for the FIFO-draining UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_CLKS_PER_BIT   = 16;
  localparam int DEFAULT_BAUD_CNT_WIDTH = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

  logic [CNT_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clear || bit_end) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bit_end = (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from an upstream FIFO and sends each as a start / LSB-first data / stop frame.
module uart_tx_drain
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int BAUD_CNT_WIDTH = DEFAULT_BAUD_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
  logic                  tx_reg, tx_next;
  logic                  baud_clear;
  logic                  bit_end;

  // Counter is held at zero outside the serial states so START always begins a full period.
  assign baud_clear = (state_reg == IDLE) || (state_reg == REQ) || (state_reg == LOAD);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_WIDTH   (BAUD_CNT_WIDTH)
  ) u_baud_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    tx_next      = 1'b1;

    case (state_reg)
      IDLE: begin
        if (enable && !fifo_empty) state_next = REQ;
      end
      REQ: begin
        state_next = LOAD;
      end
      LOAD: begin
        shift_next   = fifo_data;
        bit_idx_next = '0;
        state_next   = START;
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_next   = shift_reg >> 1;
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == LAST_IDX) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) state_next = (enable && !fifo_empty) ? REQ : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // tx is registered, so it is computed from the state being entered.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx         = tx_reg;
  assign fifo_read  = (state_reg == REQ);
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench with a FIFO model, a scoreboard of expected bytes and a line-decoding monitor.
module tb_uart_tx_drain;

  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int FRAME = CPB * (DW + 2);

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          enable     = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_read;
  logic          tx;
  logic          busy;
  logic          frame_done;

  logic          wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            read_log[$];

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int fd_count = 0;
  bit in_frame = 1'b0;

  uart_tx_drain #(
    .DATA_WIDTH    (DW),
    .CLKS_PER_BIT  (CPB),
    .BAUD_CNT_WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_read (fifo_read),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model with registered read data.
  always @(posedge clk) begin
    if (fifo_read && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [DW-1:0] b);
    tick();
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  function automatic int read_at(input int idx);
    if (idx < read_log.size()) return read_log[idx];
    return -1;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    tick();
    while (!(busy == 1'b0 && fifo_empty && !in_frame) && k < budget) begin
      tick();
      k++;
    end
    check(name, k < budget, 1'b1);
  endtask

  task automatic wait_reads(input int n, input int budget, input string name);
    int k = 0;
    while (read_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, read_log.size() >= n, 1'b1);
  endtask

  // Monitor: logs pops, decodes frames on tx and scores them against the expected queue.
  initial begin : monitor
    int               c;
    int               last_read;
    logic [DW-1:0]    b;
    logic [DW+1:0]    fb;
    logic [FRAME-1:0] act_tx, act_fd, exp_tx, exp_fd;
    bit               busy_bad;
    c = 0;
    last_read = -100;
    b = '0;
    busy_bad = 1'b0;
    act_tx = '0;
    act_fd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 1'b0;
      end else begin
        if (fifo_read) begin
          read_log.push_back(cyc);
          last_read = cyc;
          check("no_underflow", fifo_empty, 1'b0);
        end
        if (frame_done) fd_count++;
        if (!in_frame && frame_done) check("stray_frame_done", frame_done, 1'b0);
        if (!in_frame && tx == 1'b0) begin
          in_frame = 1'b1;
          c = 0;
          act_tx = '0;
          act_fd = '0;
          busy_bad = 1'b0;
          check("pop_to_start", cyc, last_read + 2);
          check("expected_frame_queued", exp_q.size() > 0, 1'b1);
          b = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        end
        if (in_frame) begin
          act_tx[c] = tx;
          act_fd[c] = frame_done;
          if (!busy) busy_bad = 1'b1;
          c++;
          if (c == FRAME) begin
            fb = {1'b1, b, 1'b0};
            for (int i = 0; i < FRAME; i++) begin
              exp_tx[i] = fb[i / CPB];
              exp_fd[i] = (i == FRAME - 1);
            end
            check("frame_bits", act_tx, exp_tx);
            check("frame_done_slot", act_fd, exp_fd);
            check("busy_in_frame", busy_bad, 1'b0);
            $display("frame byte %02h ended at cycle %0d", b, cyc);
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int base, fdb, n, k;
    bit bad_tx, bad_busy;

    repeat (3) tick();
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_fifo_read", fifo_read, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Empty FIFO, enabled: must stay quiet.
    enable = 1'b1;
    base = read_log.size();
    bad_tx = 1'b0;
    bad_busy = 1'b0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1) bad_tx = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    check("empty_no_pop", read_log.size() - base, 0);
    check("empty_tx_high", bad_tx, 1'b0);
    check("empty_not_busy", bad_busy, 1'b0);
    $display("empty fifo idle window done at cycle %0d", cyc);

    // Single byte 0xA5.
    base = read_log.size();
    fdb = fd_count;
    fifo_write(8'hA5);
    wait_idle(120, "a5_idle");
    check("a5_pops", read_log.size() - base, 1);
    check("a5_frame_done", fd_count - fdb, 1);

    // Back-to-back 0x01, 0xFF from a pre-loaded FIFO.
    enable = 1'b0;
    fifo_write(8'h01);
    fifo_write(8'hFF);
    base = read_log.size();
    fdb = fd_count;
    enable = 1'b1;
    wait_idle(200, "b2b_idle");
    check("b2b_pops", read_log.size() - base, 2);
    check("b2b_spacing", read_at(base + 1) - read_at(base), 42);
    check("b2b_frame_done", fd_count - fdb, 2);

    // enable drops during DATA of 0x3C with 0x5A queued behind it.
    enable = 1'b0;
    fifo_write(8'h3C);
    fifo_write(8'h5A);
    base = read_log.size();
    fdb = fd_count;
    enable = 1'b1;
    wait_reads(base + 1, 20, "drop_first_pop");
    n = read_at(base);
    k = 0;
    while (cyc < n + 12 && k < 50) begin
      tick();
      k++;
    end
    enable = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    repeat (20) tick();
    check("drop_single_pop", read_log.size() - base, 1);
    check("drop_frame_done", fd_count - fdb, 1);
    check("drop_idle", busy, 1'b0);
    n = cyc;
    enable = 1'b1;
    tick();
    check("resume_pop_latency", read_at(base + 1), n + 1);
    wait_idle(120, "resume_idle");
    check("resume_frames", fd_count - fdb, 2);

    // Data arrives while disabled; pop only after enable rises.
    enable = 1'b0;
    base = read_log.size();
    fifo_write(8'h96);
    repeat (20) tick();
    check("late_enable_no_pop", read_log.size() - base, 0);
    n = cyc;
    enable = 1'b1;
    tick();
    check("late_enable_pop", read_at(base), n + 1);
    wait_idle(120, "late_enable_idle");

    // Asynchronous reset in the middle of DATA.
    base = read_log.size();
    fdb = fd_count;
    fifo_write(8'hC3);
    wait_reads(base + 1, 20, "midrst_pop");
    n = read_at(base);
    k = 0;
    while (cyc < n + 10 && k < 50) begin
      tick();
      k++;
    end
    check("midrst_busy_before", busy, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_fifo_read", fifo_read, 1'b0);
    check("midrst_frame_done", frame_done, 1'b0);
    repeat (2) tick();
    @(posedge clk);
    #2 reset = 1'b0;
    bad_tx = 1'b0;
    repeat (60) begin
      tick();
      if (tx !== 1'b1) bad_tx = 1'b1;
    end
    check("midrst_no_frame_done", fd_count - fdb, 0);
    check("midrst_no_pop", read_log.size() - base, 1);
    check("midrst_tx_idle", bad_tx, 1'b0);
    $display("mid-frame reset sequence done at cycle %0d", cyc);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
